// File: rtl/MMU_defs.sv
// Purpose: shared MMU types for the TLB/PTW arbitration slice.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents: arbiter FSM state encoding, TLB selector, Sv32 VPN width and
// the 2-way round-robin pick used by the arbiter.

package MMU_defs;

  // Sv32 virtual page number width.
  localparam int unsigned VPN_W_SV32 = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RESP = 2'd2
  } type_ptw_arb_state_e;

  typedef enum logic {
    SEL_ITLB = 1'b0,
    SEL_DTLB = 1'b1
  } type_tlb_sel_e;

  // Two-way round-robin: a lone requester always wins; on a tie the side
  // that did not win last time is chosen. With no requester the result is
  // don't-care (the caller only uses it when a miss is pending).
  function automatic type_tlb_sel_e rr_pick(input logic           itlb_req,
                                            input logic           dtlb_req,
                                            input type_tlb_sel_e  last);
    type_tlb_sel_e pick;
    pick = SEL_ITLB;
    if (itlb_req && dtlb_req) begin
      pick = (last == SEL_ITLB) ? SEL_DTLB : SEL_ITLB;
    end else if (dtlb_req) begin
      pick = SEL_DTLB;
    end
    return pick;
  endfunction

endpackage

// File: rtl/tlb_ptw_arbiter.sv
// Purpose: share one page-table walker between the ITLB and the DTLB.
// Latency: miss in N -> ptw_req_o in N+1; ptw_done_i in M -> strobe in M+1.
// Backpressure: none; requesters hold their miss level until strobed.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   itlb_miss_i, itlb_vpn_i         ITLB miss request and its VPN
//   dtlb_miss_i, dtlb_vpn_i,
//   dtlb_store_i                    DTLB miss request, VPN, store flag
//   tlb_flush_i                     sfence.vma pulse
//   ptw_req_o, ptw_vpn_o,
//   ptw_store_o                     walk request to the PTW (held for walk)
//   ptw_done_i, ptw_fault_i         walk completion pulse and fault qualifier
//   itlb_update_o, itlb_fault_o,
//   dtlb_update_o, dtlb_fault_o     one-hot completion strobes to the TLBs

module tlb_ptw_arbiter
  import MMU_defs::*;
#(
  parameter int unsigned VPN_W = VPN_W_SV32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             itlb_miss_i,
  input  logic [VPN_W-1:0] itlb_vpn_i,
  input  logic             dtlb_miss_i,
  input  logic [VPN_W-1:0] dtlb_vpn_i,
  input  logic             dtlb_store_i,
  input  logic             tlb_flush_i,
  output logic             ptw_req_o,
  output logic [VPN_W-1:0] ptw_vpn_o,
  output logic             ptw_store_o,
  input  logic             ptw_done_i,
  input  logic             ptw_fault_i,
  output logic             itlb_update_o,
  output logic             dtlb_update_o,
  output logic             itlb_fault_o,
  output logic             dtlb_fault_o
);

  type_ptw_arb_state_e state_q, state_d;
  type_tlb_sel_e       owner_q, owner_d;
  type_tlb_sel_e       last_grant_q, last_grant_d;
  logic                killed_q, killed_d;
  logic                fault_q, fault_d;
  logic                store_q, store_d;
  logic [VPN_W-1:0]    vpn_q, vpn_d;

  type_tlb_sel_e       pick;
  logic                any_miss;
  logic                resp_live;

  assign any_miss = itlb_miss_i | dtlb_miss_i;
  assign pick     = rr_pick(itlb_miss_i, dtlb_miss_i, last_grant_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= SEL_ITLB;
      last_grant_q <= SEL_ITLB;  // first tie after reset goes to the DTLB
      killed_q     <= 1'b0;
      fault_q      <= 1'b0;
      store_q      <= 1'b0;
      vpn_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      killed_q     <= killed_d;
      fault_q      <= fault_d;
      store_q      <= store_d;
      vpn_q        <= vpn_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    killed_d     = killed_q;
    fault_d      = fault_q;
    store_d      = store_q;
    vpn_d        = vpn_q;

    unique case (state_q)
      IDLE: begin
        // A flush in IDLE only delays the grant by one cycle; the miss is
        // still held and gets picked up next cycle against the new tables.
        if (!tlb_flush_i && any_miss) begin
          state_d      = WALK;
          owner_d      = pick;
          last_grant_d = pick;
          killed_d     = 1'b0;
          if (pick == SEL_DTLB) begin
            vpn_d   = dtlb_vpn_i;
            store_d = dtlb_store_i;
          end else begin
            vpn_d   = itlb_vpn_i;
            store_d = 1'b0;
          end
        end
      end

      WALK: begin
        // The PTW cannot be aborted, so a flush just poisons the result.
        // A flush coincident with done is caught here as well.
        if (tlb_flush_i) begin
          killed_d = 1'b1;
        end
        if (ptw_done_i) begin
          fault_d = ptw_fault_i;
          state_d = RESP;
        end
      end

      RESP: begin
        killed_d = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ptw_req_o   = (state_q == WALK);
  assign ptw_vpn_o   = vpn_q;
  assign ptw_store_o = store_q;

  // Strobes decode purely from flopped state; the only live term is the
  // flush, which must still suppress a refill landing in the flush cycle.
  // A killed walk emits nothing: the requester keeps its miss high and is
  // re-arbitrated with a fresh walk.
  assign resp_live = (state_q == RESP) && !killed_q && !tlb_flush_i;

  assign itlb_update_o = resp_live && (owner_q == SEL_ITLB) && !fault_q;
  assign itlb_fault_o  = resp_live && (owner_q == SEL_ITLB) &&  fault_q;
  assign dtlb_update_o = resp_live && (owner_q == SEL_DTLB) && !fault_q;
  assign dtlb_fault_o  = resp_live && (owner_q == SEL_DTLB) &&  fault_q;

endmodule

// File: tb/tb_tlb_ptw_arbiter.sv
// Purpose: self-checking bench for tlb_ptw_arbiter with a PTW/TLB model.
// Latency: n/a.
// Backpressure: n/a.

module tb_tlb_ptw_arbiter;
  import MMU_defs::*;

  localparam int VPN_W = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             itlb_miss_i = 1'b0;
  logic [VPN_W-1:0] itlb_vpn_i = '0;
  logic             dtlb_miss_i = 1'b0;
  logic [VPN_W-1:0] dtlb_vpn_i = '0;
  logic             dtlb_store_i = 1'b0;
  logic             tlb_flush_i = 1'b0;
  logic             ptw_req_o;
  logic [VPN_W-1:0] ptw_vpn_o;
  logic             ptw_store_o;
  logic             ptw_done_i = 1'b0;
  logic             ptw_fault_i = 1'b0;
  logic             itlb_update_o, dtlb_update_o, itlb_fault_o, dtlb_fault_o;

  tlb_ptw_arbiter #(.VPN_W(VPN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .itlb_miss_i  (itlb_miss_i),
    .itlb_vpn_i   (itlb_vpn_i),
    .dtlb_miss_i  (dtlb_miss_i),
    .dtlb_vpn_i   (dtlb_vpn_i),
    .dtlb_store_i (dtlb_store_i),
    .tlb_flush_i  (tlb_flush_i),
    .ptw_req_o    (ptw_req_o),
    .ptw_vpn_o    (ptw_vpn_o),
    .ptw_store_o  (ptw_store_o),
    .ptw_done_i   (ptw_done_i),
    .ptw_fault_i  (ptw_fault_i),
    .itlb_update_o(itlb_update_o),
    .dtlb_update_o(dtlb_update_o),
    .itlb_fault_o (itlb_fault_o),
    .dtlb_fault_o (dtlb_fault_o)
  );

  always #5 clk = ~clk;

  // Strobe encoding used by the scoreboard: {itlb_upd, itlb_flt, dtlb_upd, dtlb_flt}
  localparam logic [3:0] S_IU = 4'b1000;
  localparam logic [3:0] S_IF = 4'b0100;
  localparam logic [3:0] S_DU = 4'b0010;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;
  int req_cnt  = 0;
  int ptw_lat  = 4;
  logic ptw_flt = 1'b0;
  int ptw_cnt  = 0;
  logic        req_d = 1'b0;
  logic [20:0] held = '0;
  type_tlb_sel_e exp_last = SEL_ITLB;

  logic [20:0] exp_walk[$];   // {store, vpn} expected at each walk start
  logic [3:0]  exp_strb[$];   // expected strobe per completed walk
  int          rise_q[$];     // cycles where ptw_req_o rose
  int          strb_q[$];     // cycles where a strobe was seen

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // PTW model: pulse done after ptw_lat cycles of ptw_req_o.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      ptw_done_i  = 1'b0;
      ptw_fault_i = 1'b0;
      ptw_cnt     = 0;
    end else if (ptw_req_o && !ptw_done_i) begin
      ptw_cnt++;
      if (ptw_cnt == ptw_lat) begin
        ptw_done_i  = 1'b1;
        ptw_fault_i = ptw_flt;
      end
    end else begin
      ptw_done_i  = 1'b0;
      ptw_fault_i = 1'b0;
      ptw_cnt     = 0;
    end
  end

  always @(posedge clk) begin
    if (rst_n && ptw_done_i)
      assert (ptw_req_o) else $error("FAIL done_outside_walk at cycle %0d", cyc);
  end

  // One clock: sample at negedge against the scoreboard, then advance to
  // just after the next rising edge and apply the TLB model (drop a miss
  // once its strobe has been seen).
  task automatic tick();
    logic [3:0] s;
    logic drop_i, drop_d;
    drop_i = 1'b0;
    drop_d = 1'b0;
    @(negedge clk);
    s = {itlb_update_o, itlb_fault_o, dtlb_update_o, dtlb_fault_o};
    if (s != 4'b0) begin
      check_val("strobe_onehot", 32'($countones(s)), 32'd1);
      strb_q.push_back(cyc);
      if (exp_strb.size() == 0) check_val("strobe_unexpected", 32'(s), 32'd0);
      else check_val("strobe_kind", 32'(s), 32'(exp_strb.pop_front()));
      drop_i = s[3] | s[2];
      drop_d = s[1] | s[0];
    end
    if (ptw_req_o) begin
      req_cnt++;
      if (!req_d) begin
        rise_q.push_back(cyc);
        if (exp_walk.size() == 0) begin
          check_val("walk_unexpected", 32'({ptw_store_o, ptw_vpn_o}), 32'hffff_ffff);
        end else begin
          held = exp_walk.pop_front();
          check_val("walk_start", 32'({ptw_store_o, ptw_vpn_o}), 32'(held));
        end
      end else begin
        check_val("walk_stable", 32'({ptw_store_o, ptw_vpn_o}), 32'(held));
      end
    end
    req_d = ptw_req_o;
    @(posedge clk);
    #1;
    cyc++;
    if (drop_i) itlb_miss_i = 1'b0;
    if (drop_d) dtlb_miss_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_strb.size() != 0 || exp_walk.size() != 0 || ptw_req_o) && n < budget) begin
      tick();
      n++;
    end
    check_val("drain_strobes", 32'(exp_strb.size()), 32'd0);
    check_val("drain_walks", 32'(exp_walk.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic new_test();
    rise_q.delete();
    strb_q.delete();
    req_cnt = 0;
    base = cyc;
  endtask

  function automatic int rise_at(input int idx);
    return (rise_q.size() > idx) ? rise_q[idx] - base : -1;
  endfunction

  function automatic int strb_at(input int idx);
    return (strb_q.size() > idx) ? strb_q[idx] - base : -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    type_tlb_sel_e first;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs",
              32'({ptw_req_o, ptw_store_o, ptw_vpn_o, itlb_update_o, itlb_fault_o,
                   dtlb_update_o, dtlb_fault_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;

    // Simultaneous misses from reset: DTLB wins first, ITLB follows.
    new_test();
    ptw_lat = 4;
    itlb_vpn_i = 20'h0AAAA; dtlb_vpn_i = 20'h0BBBB; dtlb_store_i = 1'b1;
    itlb_miss_i = 1'b1; dtlb_miss_i = 1'b1;
    exp_walk.push_back({1'b1, 20'h0BBBB});
    exp_walk.push_back({1'b0, 20'h0AAAA});
    exp_strb.push_back(S_DU);
    exp_strb.push_back(S_IU);
    drain(60);
    check_val("rr_first_rise", 32'(rise_at(0)), 32'd1);
    check_val("rr_second_rise", 32'(rise_at(1)), 32'd7);
    exp_last = SEL_ITLB;
    dtlb_store_i = 1'b0;

    // Lone DTLB miss, 5-cycle walk.
    new_test();
    ptw_lat = 5;
    dtlb_vpn_i = 20'h12345;
    dtlb_miss_i = 1'b1;
    exp_walk.push_back({1'b0, 20'h12345});
    exp_strb.push_back(S_DU);
    drain(60);
    check_val("single_rise", 32'(rise_at(0)), 32'd1);
    check_val("single_req_cycles", 32'(req_cnt), 32'd5);
    check_val("single_strobe_cycle", 32'(strb_at(0)), 32'd6);
    check_val("single_strobe_count", 32'(strb_q.size()), 32'd1);
    exp_last = SEL_DTLB;

    // Four rounds of simultaneous misses: the bench's own round-robin model.
    for (int r = 0; r < 4; r++) begin
      new_test();
      ptw_lat = 3;
      itlb_vpn_i   = 20'h10000 + 20'(r);
      dtlb_vpn_i   = 20'h20000 + 20'(r);
      dtlb_store_i = r[0];
      itlb_miss_i = 1'b1; dtlb_miss_i = 1'b1;
      first = (exp_last == SEL_ITLB) ? SEL_DTLB : SEL_ITLB;
      if (first == SEL_DTLB) begin
        exp_walk.push_back({r[0], 20'h20000 + 20'(r)});
        exp_walk.push_back({1'b0, 20'h10000 + 20'(r)});
        exp_strb.push_back(S_DU);
        exp_strb.push_back(S_IU);
        exp_last = SEL_ITLB;
      end else begin
        exp_walk.push_back({1'b0, 20'h10000 + 20'(r)});
        exp_walk.push_back({r[0], 20'h20000 + 20'(r)});
        exp_strb.push_back(S_IU);
        exp_strb.push_back(S_DU);
        exp_last = SEL_DTLB;
      end
      drain(60);
      check_val("round_second_rise", 32'(rise_at(1)), 32'd6);
    end
    dtlb_store_i = 1'b0;

    // ITLB walk ending in a fault.
    new_test();
    ptw_lat = 3;
    ptw_flt = 1'b1;
    itlb_vpn_i = 20'h0F00D;
    itlb_miss_i = 1'b1;
    exp_walk.push_back({1'b0, 20'h0F00D});
    exp_strb.push_back(S_IF);
    drain(60);
    check_val("fault_strobe_cycle", 32'(strb_at(0)), 32'd4);
    check_val("fault_strobe_count", 32'(strb_q.size()), 32'd1);
    ptw_flt = 1'b0;

    // Flush in the middle of a DTLB walk: no strobe, then a fresh walk.
    new_test();
    ptw_lat = 6;
    dtlb_vpn_i = 20'h0CAFE;
    dtlb_miss_i = 1'b1;
    exp_walk.push_back({1'b0, 20'h0CAFE});
    exp_walk.push_back({1'b0, 20'h0CAFE});
    exp_strb.push_back(S_DU);
    repeat (3) tick();
    tlb_flush_i = 1'b1;
    tick();
    tlb_flush_i = 1'b0;
    drain(80);
    check_val("flush_walk_regrant", 32'(rise_at(1)), 32'd9);
    check_val("flush_walk_strobe", 32'(strb_at(0)), 32'd15);

    // Flush coinciding with a new miss in IDLE delays the grant one cycle.
    new_test();
    ptw_lat = 2;
    itlb_vpn_i = 20'h01111;
    itlb_miss_i = 1'b1;
    tlb_flush_i = 1'b1;
    exp_walk.push_back({1'b0, 20'h01111});
    exp_strb.push_back(S_IU);
    tick();
    tlb_flush_i = 1'b0;
    drain(60);
    check_val("flush_idle_rise", 32'(rise_at(0)), 32'd2);

    // Flush in the same cycle as ptw_done_i counts as killed.
    new_test();
    ptw_lat = 3;
    itlb_vpn_i = 20'h02222;
    itlb_miss_i = 1'b1;
    exp_walk.push_back({1'b0, 20'h02222});
    exp_walk.push_back({1'b0, 20'h02222});
    exp_strb.push_back(S_IU);
    repeat (3) tick();
    tlb_flush_i = 1'b1;
    tick();
    tlb_flush_i = 1'b0;
    drain(60);
    check_val("flush_done_regrant", 32'(rise_at(1)), 32'd6);
    check_val("flush_done_strobe", 32'(strb_at(0)), 32'd9);

    // Reset asserted mid-walk, then normal service afterwards.
    new_test();
    ptw_lat = 8;
    dtlb_vpn_i = 20'h0DEAD;
    dtlb_miss_i = 1'b1;
    exp_walk.push_back({1'b0, 20'h0DEAD});
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("reset_mid_walk",
              32'({ptw_req_o, ptw_store_o, ptw_vpn_o, itlb_update_o, itlb_fault_o,
                   dtlb_update_o, dtlb_fault_o}), 32'd0);
    dtlb_miss_i = 1'b0;
    exp_walk.delete();
    exp_strb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    new_test();
    ptw_lat = 2;
    itlb_vpn_i = 20'h03333;
    itlb_miss_i = 1'b1;
    exp_walk.push_back({1'b0, 20'h03333});
    exp_strb.push_back(S_IU);
    drain(60);
    check_val("post_reset_rise", 32'(rise_at(0)), 32'd1);
    check_val("post_reset_strobe", 32'(strb_at(0)), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
